// File: rtl/demux12_tdm.sv
// Splits a shared channel-select word stream back into registered channels a and b,
// checking the a-then-b pairing order and counting out-of-order words.
module demux12_tdm #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             s,
    input  logic             clr_err,
    output logic [WIDTH-1:0] xa,
    output logic [WIDTH-1:0] xb,
    output logic             xa_valid,
    output logic             xb_valid,
    output logic             pair_valid,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic             pair_nxt;
    logic             err_nxt;

    logic [WIDTH-1:0] xa_p1;
    logic [WIDTH-1:0] xb_p1;
    logic             vld_a_p1;
    logic             vld_b_p1;
    logic             pair_vld_p1;
    logic             seq_err_p1;
    logic [ERR_W-1:0] err_cnt_p1;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_A;
        else     state <= state_nxt;
    end

    // Pairing decision for the word presented this cycle.
    always_comb begin
        state_nxt = state;
        pair_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (din_valid) begin
            case (state)
                WAIT_A: begin
                    if (!s) state_nxt = WAIT_B;
                    else    err_nxt   = 1'b1;
                end
                WAIT_B: begin
                    if (s) begin
                        pair_nxt  = 1'b1;
                        state_nxt = WAIT_A;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                end
                default: state_nxt = WAIT_A;
            endcase
        end
    end

    // Stage p1: channel registers, pulses and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            xa_p1       <= '0;
            xb_p1       <= '0;
            vld_a_p1    <= 1'b0;
            vld_b_p1    <= 1'b0;
            pair_vld_p1 <= 1'b0;
            seq_err_p1  <= 1'b0;
            err_cnt_p1  <= '0;
        end else begin
            vld_a_p1    <= 1'b0;
            vld_b_p1    <= 1'b0;
            pair_vld_p1 <= pair_nxt;
            seq_err_p1  <= err_nxt;
            if (din_valid) begin
                if (!s) begin
                    xa_p1    <= din;
                    vld_a_p1 <= 1'b1;
                end else begin
                    xb_p1    <= din;
                    vld_b_p1 <= 1'b1;
                end
            end
            // A clear coinciding with a new error keeps that error counted.
            if (clr_err)
                err_cnt_p1 <= err_nxt ? {{(ERR_W-1){1'b0}}, 1'b1} : '0;
            else if (err_nxt)
                err_cnt_p1 <= sat_inc(err_cnt_p1);
        end
    end

    assign xa         = xa_p1;
    assign xb         = xb_p1;
    assign xa_valid   = vld_a_p1;
    assign xb_valid   = vld_b_p1;
    assign pair_valid = pair_vld_p1;
    assign seq_err    = seq_err_p1;
    assign err_count  = err_cnt_p1;

endmodule

// File: tb/tb_demux12_tdm.sv
// Randomized self-checking bench for demux12_tdm against a last-select reference model,
// with a second instance at ERR_W=2 to exercise counter saturation.
module tb_demux12_tdm;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             s;
    logic             clr_err;

    logic [WIDTH-1:0] xa, xb, xa2, xb2;
    logic             xa_valid, xb_valid, pair_valid, seq_err;
    logic             xa_valid2, xb_valid2, pair_valid2, seq_err2;
    logic [7:0]       err_count;
    logic [1:0]       err_count2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pairing state is simply "the last accepted word was channel a".
    logic [WIDTH-1:0] m_xa, m_xb;
    logic             m_xav, m_xbv, m_pair, m_err;
    int               m_cnt8, m_cnt2;
    logic             m_last_a;
    int               obs_pairs, exp_pairs;

    demux12_tdm #(.WIDTH(WIDTH), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .s(s), .clr_err(clr_err),
        .xa(xa), .xb(xb), .xa_valid(xa_valid), .xb_valid(xb_valid),
        .pair_valid(pair_valid), .seq_err(seq_err), .err_count(err_count)
    );

    demux12_tdm #(.WIDTH(WIDTH), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .s(s), .clr_err(clr_err),
        .xa(xa2), .xb(xb2), .xa_valid(xa_valid2), .xb_valid(xb_valid2),
        .pair_valid(pair_valid2), .seq_err(seq_err2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int next_cnt(input int cnt, input int maxv, input logic err, input logic clr);
        if (clr) return err ? 1 : 0;
        if (err) return (cnt < maxv) ? cnt + 1 : maxv;
        return cnt;
    endfunction

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                        input logic clr, input logic r);
        din_valid = v;
        s         = sel;
        din       = d;
        clr_err   = clr;
        rst       = r;
        @(posedge clk);
        #1;
        m_xav  = 1'b0;
        m_xbv  = 1'b0;
        m_pair = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_xa     = '0;
            m_xb     = '0;
            m_cnt8   = 0;
            m_cnt2   = 0;
            m_last_a = 1'b0;
        end else begin
            if (v) begin
                if (!sel) begin
                    m_xa  = d;
                    m_xav = 1'b1;
                    m_err = m_last_a;
                end else begin
                    m_xb   = d;
                    m_xbv  = 1'b1;
                    m_pair = m_last_a;
                    m_err  = !m_last_a;
                end
                m_last_a = !sel;
            end
            m_cnt8 = next_cnt(m_cnt8, 255, m_err, clr);
            m_cnt2 = next_cnt(m_cnt2, 3, m_err, clr);
        end
        if (pair_valid) obs_pairs++;
        chk("xa",         32'(xa),         32'(m_xa));
        chk("xb",         32'(xb),         32'(m_xb));
        chk("xa_valid",   32'(xa_valid),   32'(m_xav));
        chk("xb_valid",   32'(xb_valid),   32'(m_xbv));
        chk("pair_valid", 32'(pair_valid), 32'(m_pair));
        chk("seq_err",    32'(seq_err),    32'(m_err));
        chk("err_count",  32'(err_count),  32'(m_cnt8));
        chk("err_count2", 32'(err_count2), 32'(m_cnt2));
        chk("xa2",        32'(xa2),        32'(m_xa));
        chk("xb2",        32'(xb2),        32'(m_xb));
        chk("pair2",      32'(pair_valid2), 32'(m_pair));
        chk("seq_err2",   32'(seq_err2),   32'(m_err));
        chk("xa_valid2",  32'(xa_valid2),  32'(m_xav));
        chk("xb_valid2",  32'(xb_valid2),  32'(m_xbv));
    endtask

    initial begin
        m_xa = '0; m_xb = '0; m_cnt8 = 0; m_cnt2 = 0; m_last_a = 1'b0;
        obs_pairs = 0; exp_pairs = 0;

        // Reset state, then a clean a,b pair.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        chk("pair_a_xa", 32'(xa), 32'hA5);
        step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("pair_b_pair", 32'(pair_valid), 32'd1);

        // Idle cycles with toggling din/s: nothing moves.
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'(i), 8'($urandom), 1'b0, 1'b0);

        // Out-of-order sequence from reset.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        chk("b_first_cnt", 32'(err_count), 32'd1);
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        chk("a_twice_cnt", 32'(err_count), 32'd2);
        step(1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        chk("pair_33_44", 32'({xa, xb, pair_valid}), 32'({8'h33, 8'h44, 1'b1}));

        // Saturation on the 2-bit counter, then clear with and without an error.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        chk("sat_at_3", 32'(err_count2), 32'd3);
        step(1'b1, 1'b1, 8'h56, 1'b1, 1'b0);
        chk("clr_with_err", 32'(err_count2), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("clr_alone", 32'(err_count2), 32'd0);

        // Reset wins over a word in the same cycle and discards the partial pair.
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h88, 1'b0, 1'b1);
        chk("rst_xa", 32'(xa), 32'd0);
        step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        chk("post_rst_err", 32'(seq_err), 32'd1);

        // Full-rate random words with occasional clears.
        obs_pairs = 0;
        exp_pairs = 0;
        begin
            logic prev_a;
            logic sel;
            prev_a = m_last_a;
            for (int i = 0; i < 100; i++) begin
                sel = 1'($urandom);
                if (sel && prev_a) exp_pairs++;
                prev_a = !sel;
                step(1'b1, sel, 8'($urandom), ($urandom_range(0, 15) == 0), 1'b0);
            end
        end
        chk("pair_total", 32'(obs_pairs), 32'(exp_pairs));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
